// File: rtl/uga_dyna_pkg.sv
// Shared Dynamixel protocol types, constants and helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uga_dyna_pkg;

  localparam logic [7:0] DYNA_PREAMBLE = 8'hFF;

  typedef enum logic [2:0] {
    HUNT1,
    HUNT2,
    ID,
    LEN,
    ERR,
    PARAM,
    CSUM
  } dyna_rx_state_t;

  // Status error byte, MSB first.
  typedef struct packed {
    logic reserved;
    logic instruction;
    logic overload;
    logic checksum;
    logic range;
    logic overheat;
    logic angle;
    logic voltage;
  } error_byte_t;

  // A status LENGTH covers error + params + checksum, so it is at least 2
  // and may carry no more than max parameters.
  function automatic logic dyna_status_len_ok(input logic [7:0] len, input int max);
    return (int'(len) >= 2) && (int'(len) - 2 <= max);
  endfunction

  // Expected checksum of a status packet with up to four params; unused
  // param bytes must be zero for this to match the parser.
  function automatic logic [7:0] dyna_status_checksum(input logic [7:0]  id,
                                                      input logic [7:0]  len,
                                                      input logic [7:0]  err,
                                                      input logic [31:0] params);
    logic [7:0] s;
    s = id + len + err;
    for (int i = 0; i < 4; i++) s = s + params[i*8 +: 8];
    return ~s;
  endfunction

endpackage

// File: rtl/uga_dyna_csum_acc.sv
// 8-bit running-sum accumulator presenting the inverted sum as a checksum.
// Latency: sum registered, csum_o reflects bytes added up to the previous cycle.
// Backpressure: none; adds whatever is presented with add_i.
module uga_dyna_csum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  output logic [7:0] csum_o
);

  logic [7:0] sum_q, sum_d;

  // clr and add together load data_i as the first term of a new sum.
  always_comb begin
    sum_d = clr_i ? 8'h00 : sum_q;
    if (add_i) sum_d = sum_d + data_i;
  end

  // Sum register.
  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'h00;
    else     sum_q <= sum_d;
  end

  assign csum_o = ~sum_q;

endmodule

// File: rtl/uga_dyna_status_rx.sv
// Parses Dynamixel status packets from the UART RX byte stream.
// Latency: pkt_valid/len_err/timeout one cycle after the deciding byte or idle cycle.
// Backpressure: none; accepts one byte per cycle, back-to-back.
module uga_dyna_status_rx
  import uga_dyna_pkg::*;
#(
  parameter int MAX_PARAM   = 4,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  input  logic [7:0]                     expect_id,
  input  logic                           expect_en,
  output logic                           pkt_valid,
  output logic [7:0]                     pkt_id,
  output logic [7:0]                     pkt_error,
  output logic [MAX_PARAM*8-1:0]         pkt_param,
  output logic [$clog2(MAX_PARAM+1)-1:0] pkt_nparam,
  output logic                           pkt_csum_err,
  output logic                           len_err,
  output logic                           timeout,
  output logic                           busy
);

  localparam int NW = $clog2(MAX_PARAM + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  dyna_rx_state_t       state_q, state_d;
  logic [7:0]           id_q, id_d;
  error_byte_t          err_q, err_d;
  logic [NW-1:0]        n_q, n_d, k_q, k_d;
  logic [7:0]           param_q [MAX_PARAM];
  logic [7:0]           param_d [MAX_PARAM];
  logic [TW-1:0]        tmo_q, tmo_d;

  logic                 pkt_valid_q, pkt_valid_d;
  logic [7:0]           pkt_id_q, pkt_id_d;
  logic [7:0]           pkt_error_q, pkt_error_d;
  logic [MAX_PARAM*8-1:0] pkt_param_q, pkt_param_d;
  logic [NW-1:0]        pkt_nparam_q, pkt_nparam_d;
  logic                 pkt_csum_err_q, pkt_csum_err_d;
  logic                 len_err_q, len_err_d;
  logic                 timeout_q, timeout_d;

  logic                 acc_clr, acc_add;
  logic [7:0]           acc_csum;

  uga_dyna_csum_acc u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .data_i (rx_data),
    .csum_o (acc_csum)
  );

  assign busy = (state_q != HUNT1);

  // Next-state: inter-byte timeout first, then per-byte protocol decoding.
  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    err_d          = err_q;
    n_d            = n_q;
    k_d            = k_q;
    param_d        = param_q;
    tmo_d          = tmo_q;
    pkt_valid_d    = 1'b0;
    pkt_id_d       = pkt_id_q;
    pkt_error_d    = pkt_error_q;
    pkt_param_d    = pkt_param_q;
    pkt_nparam_d   = pkt_nparam_q;
    pkt_csum_err_d = pkt_csum_err_q;
    len_err_d      = 1'b0;
    timeout_d      = 1'b0;
    acc_clr        = 1'b0;
    acc_add        = 1'b0;

    // A byte on the terminal-count cycle clears the counter, so it wins.
    if (!busy || rx_valid) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d     = '0;
      timeout_d = 1'b1;
      state_d   = HUNT1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (rx_valid) begin
      case (state_q)
        HUNT1: if (rx_data == DYNA_PREAMBLE) state_d = HUNT2;
        HUNT2: state_d = (rx_data == DYNA_PREAMBLE) ? ID : HUNT1;
        ID: begin
          if (rx_data != DYNA_PREAMBLE) begin
            id_d    = rx_data;
            acc_clr = 1'b1;
            acc_add = 1'b1;
            state_d = LEN;
          end
        end
        LEN: begin
          if (!dyna_status_len_ok(rx_data, MAX_PARAM)) begin
            len_err_d = 1'b1;
            state_d   = HUNT1;
          end else begin
            n_d     = NW'(rx_data - 8'd2);
            k_d     = '0;
            acc_add = 1'b1;
            for (int i = 0; i < MAX_PARAM; i++) param_d[i] = 8'h00;
            state_d = ERR;
          end
        end
        ERR: begin
          err_d   = error_byte_t'(rx_data);
          acc_add = 1'b1;
          state_d = (n_q == '0) ? CSUM : PARAM;
        end
        PARAM: begin
          for (int i = 0; i < MAX_PARAM; i++) begin
            if (k_q == NW'(i)) param_d[i] = rx_data;
          end
          acc_add = 1'b1;
          k_d     = k_q + NW'(1);
          if (k_q + NW'(1) == n_q) state_d = CSUM;
        end
        CSUM: begin
          state_d = HUNT1;
          // Packets for another servo are consumed silently.
          if (!expect_en || (id_q == expect_id)) begin
            pkt_valid_d    = 1'b1;
            pkt_id_d       = id_q;
            pkt_error_d    = err_q;
            pkt_nparam_d   = n_q;
            pkt_csum_err_d = (rx_data != acc_csum);
            for (int i = 0; i < MAX_PARAM; i++) pkt_param_d[i*8 +: 8] = param_q[i];
          end
        end
        default: state_d = HUNT1;
      endcase
    end
  end

  // State, packet buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HUNT1;
      id_q           <= 8'h00;
      err_q          <= '0;
      n_q            <= '0;
      k_q            <= '0;
      tmo_q          <= '0;
      for (int i = 0; i < MAX_PARAM; i++) param_q[i] <= 8'h00;
      pkt_valid_q    <= 1'b0;
      pkt_id_q       <= 8'h00;
      pkt_error_q    <= 8'h00;
      pkt_param_q    <= '0;
      pkt_nparam_q   <= '0;
      pkt_csum_err_q <= 1'b0;
      len_err_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      err_q          <= err_d;
      n_q            <= n_d;
      k_q            <= k_d;
      tmo_q          <= tmo_d;
      param_q        <= param_d;
      pkt_valid_q    <= pkt_valid_d;
      pkt_id_q       <= pkt_id_d;
      pkt_error_q    <= pkt_error_d;
      pkt_param_q    <= pkt_param_d;
      pkt_nparam_q   <= pkt_nparam_d;
      pkt_csum_err_q <= pkt_csum_err_d;
      len_err_q      <= len_err_d;
      timeout_q      <= timeout_d;
    end
  end

  assign pkt_valid    = pkt_valid_q;
  assign pkt_id       = pkt_id_q;
  assign pkt_error    = pkt_error_q;
  assign pkt_param    = pkt_param_q;
  assign pkt_nparam   = pkt_nparam_q;
  assign pkt_csum_err = pkt_csum_err_q;
  assign len_err      = len_err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_uga_dyna_status_rx.sv
// Self-checking bench for uga_dyna_status_rx (MAX_PARAM=4, TIMEOUT_CYC=16).
// Latency: outputs checked 1 time unit after every rising edge.
// Backpressure: n/a.
module tb_uga_dyna_status_rx;

  localparam int MAXP = 4;
  localparam int TMO  = 16;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  expect_id;
  logic        expect_en;
  logic        pkt_valid;
  logic [7:0]  pkt_id;
  logic [7:0]  pkt_error;
  logic [31:0] pkt_param;
  logic [2:0]  pkt_nparam;
  logic        pkt_csum_err;
  logic        len_err;
  logic        timeout;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int n_pkt, n_lenerr, n_tmo;

  uga_dyna_status_rx #(.MAX_PARAM(MAXP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .expect_id(expect_id), .expect_en(expect_en),
    .pkt_valid(pkt_valid), .pkt_id(pkt_id), .pkt_error(pkt_error),
    .pkt_param(pkt_param), .pkt_nparam(pkt_nparam), .pkt_csum_err(pkt_csum_err),
    .len_err(len_err), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the bytes of the packet being collected, plus the
  // values the outputs must show after the current edge.
  logic [7:0]  mbuf [$];
  int          idle_n;
  logic        e_pv, e_le, e_to, e_ce;
  logic [7:0]  e_id, e_err;
  logic [31:0] e_par;
  logic [2:0]  e_np;

  task automatic model_finish();
    logic [7:0] s;
    int n;
    s = 8'h00;
    for (int i = 2; i < mbuf.size() - 1; i++) s = s + mbuf[i];
    n = int'(mbuf[3]) - 2;
    if (!expect_en || mbuf[2] == expect_id) begin
      e_pv  = 1'b1;
      e_id  = mbuf[2];
      e_err = mbuf[4];
      e_np  = 3'(n);
      e_ce  = (mbuf[mbuf.size()-1] != ~s);
      e_par = 32'h0;
      for (int i = 0; i < n; i++) e_par[i*8 +: 8] = mbuf[5+i];
    end
    mbuf.delete();
  endtask

  task automatic model_byte(input logic [7:0] d);
    case (mbuf.size())
      0: if (d == 8'hFF) mbuf.push_back(d);
      1: if (d == 8'hFF) mbuf.push_back(d); else mbuf.delete();
      2: if (d != 8'hFF) mbuf.push_back(d);
      3: begin
        if (int'(d) < 2 || int'(d) - 2 > MAXP) begin
          e_le = 1'b1;
          mbuf.delete();
        end else begin
          mbuf.push_back(d);
        end
      end
      default: begin
        mbuf.push_back(d);
        // Packet = FF FF ID LEN + LEN bytes.
        if (mbuf.size() == int'(mbuf[3]) + 4) model_finish();
      end
    endcase
  endtask

  // Compare process: advance the model on every edge, then check all outputs.
  initial begin
    idle_n = 0;
    e_id = 0; e_err = 0; e_par = 0; e_np = 0; e_ce = 0;
    forever begin
      @(posedge clk);
      e_pv = 1'b0; e_le = 1'b0; e_to = 1'b0;
      if (rst) begin
        mbuf.delete();
        idle_n = 0;
        e_id = 0; e_err = 0; e_par = 0; e_np = 0; e_ce = 0;
      end else if (rx_valid) begin
        idle_n = 0;
        model_byte(rx_data);
      end else if (mbuf.size() != 0) begin
        idle_n++;
        if (idle_n == TMO) begin
          e_to = 1'b1;
          mbuf.delete();
          idle_n = 0;
        end
      end
      #1;
      chk("pkt_valid",    32'(pkt_valid),    32'(e_pv));
      chk("len_err",      32'(len_err),      32'(e_le));
      chk("timeout",      32'(timeout),      32'(e_to));
      chk("busy",         32'(busy),         32'(mbuf.size() != 0));
      chk("pkt_id",       32'(pkt_id),       32'(e_id));
      chk("pkt_error",    32'(pkt_error),    32'(e_err));
      chk("pkt_param",    pkt_param,         e_par);
      chk("pkt_nparam",   32'(pkt_nparam),   32'(e_np));
      chk("pkt_csum_err", 32'(pkt_csum_err), 32'(e_ce));
      if (pkt_valid) n_pkt++;
      if (len_err)   n_lenerr++;
      if (timeout)   n_tmo++;
    end
  end

  task automatic send(input byte_q_t q);
    foreach (q[i]) begin
      @(negedge clk);
      rx_data  = q[i];
      rx_valid = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic clr_counts();
    n_pkt = 0; n_lenerr = 0; n_tmo = 0;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; expect_id = 8'h00; expect_en = 1'b0;
    clr_counts();
    idle(3);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_pkt_param", pkt_param,      32'd0);
    rst = 1'b0;

    // 1: minimal packet, no params.
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC}); idle(3);
    chk("t1_npkt",   32'(n_pkt),        32'd1);
    chk("t1_id",     32'(pkt_id),       32'h01);
    chk("t1_nparam", 32'(pkt_nparam),   32'd0);
    chk("t1_csum",   32'(pkt_csum_err), 32'd0);

    // 2: two params, good then bad checksum.
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD8}); idle(3);
    chk("t2_npkt",   32'(n_pkt),        32'd1);
    chk("t2_param",  pkt_param,         32'h0000_0220);
    chk("t2_nparam", 32'(pkt_nparam),   32'd2);
    chk("t2_csum",   32'(pkt_csum_err), 32'd0);
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD7}); idle(3);
    chk("t2b_npkt",  32'(n_pkt),        32'd1);
    chk("t2b_csum",  32'(pkt_csum_err), 32'd1);

    // 3: noise and extra preamble, back-to-back.
    clr_counts();
    send('{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h24, 8'hD8}); idle(3);
    chk("t3_npkt",   32'(n_pkt),     32'd1);
    chk("t3_id",     32'(pkt_id),    32'h01);
    chk("t3_err",    32'(pkt_error), 32'h24);
    chk("t3_param",  pkt_param,      32'd0);

    // 4: oversize length, then recovery.
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h08, 8'h00, 8'h11}); idle(3);
    chk("t4_lenerr", 32'(n_lenerr), 32'd1);
    chk("t4_npkt",   32'(n_pkt),    32'd0);
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h01}); idle(2);
    chk("t4_len1",   32'(n_lenerr), 32'd1);
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC}); idle(3);
    chk("t4b_npkt",  32'(n_pkt),    32'd1);

    // 5: ID filter.
    expect_en = 1'b1; expect_id = 8'h02;
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h05, 8'h20, 8'h02, 8'hD3}); idle(3);
    chk("t5_npkt",   32'(n_pkt),     32'd0);
    chk("t5_hold",   32'(pkt_id),    32'h01);
    send('{8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB}); idle(3);
    chk("t5b_npkt",  32'(n_pkt),     32'd1);
    chk("t5b_id",    32'(pkt_id),    32'h02);
    expect_en = 1'b0;

    // 6: timeout, byte on terminal count, reset mid-packet.
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01}); idle(20);
    chk("t6_tmo",    32'(n_tmo),     32'd1);
    chk("t6_busy",   32'(busy),      32'd0);
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01}); idle(TMO - 1);
    send('{8'h02, 8'h00, 8'hFC}); idle(3);
    chk("t6b_tmo",   32'(n_tmo),     32'd0);
    chk("t6b_npkt",  32'(n_pkt),     32'd1);
    clr_counts();
    send('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00}); idle(1);
    rst = 1'b1; idle(2); rst = 1'b0;
    chk("t6c_busy",  32'(busy),      32'd0);
    chk("t6c_id",    32'(pkt_id),    32'h00);
    send('{8'hFF, 8'hFF, 8'h03, 8'h03, 8'h00, 8'h5A, 8'h9F}); idle(TMO + 4);
    chk("t6c_npkt",  32'(n_pkt),     32'd1);
    chk("t6c_tmo",   32'(n_tmo),     32'd0);
    chk("t6c_lenerr",32'(n_lenerr),  32'd0);
    chk("t6c_param", pkt_param,      32'h0000_005A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
